// File: rtl/sad_fetch.sv
`default_nettype none
// ============================================================================
// Module   : sad_fetch
// Brief    : Fetches SAMPLES pixel pairs per load from memories A/B into lanes.
// Revision : 1.0
// ============================================================================
module sad_fetch #(
    parameter int DATA_W  = 8,
    parameter int SAMPLES = 4,
    parameter int TOTAL   = 16,
    parameter int ADDR_W  = 4,
    parameter int MEM_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      load,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_rd_en,
    input  logic [DATA_W-1:0]         mem_a_data,
    input  logic [DATA_W-1:0]         mem_b_data,
    output logic [SAMPLES*DATA_W-1:0] a_out,
    output logic [SAMPLES*DATA_W-1:0] b_out,
    output logic                      loaded,
    output logic                      counter
);

    localparam int IDX_W = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    localparam logic [IDX_W-1:0]  C_LAST_IDX   = IDX_W'(SAMPLES - 1);
    localparam logic [LAT_W-1:0]  C_LAST_DRAIN = LAT_W'(MEM_LAT - 1);
    localparam logic [ADDR_W:0]   C_STEP       = (ADDR_W + 1)'(SAMPLES);
    localparam logic [ADDR_W:0]   C_TOTAL      = (ADDR_W + 1)'(TOTAL);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_flush;
    logic [IDX_W-1:0]    r_idx;
    logic [LAT_W-1:0]    r_drain;
    logic [ADDR_W-1:0]   r_pointer;
    logic                r_counter;
    logic [ADDR_W:0]     w_ptr_sum;
    logic [ADDR_W-1:0]   w_ptr_next;

    logic                r_vld  [MEM_LAT];
    logic [IDX_W-1:0]    r_tidx [MEM_LAT];
    logic [DATA_W-1:0]   r_a_lane [SAMPLES];
    logic [DATA_W-1:0]   r_b_lane [SAMPLES];

    assign w_flush = rst | clear;

    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        loaded    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (load) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                mem_rd_en = 1'b1;
                mem_addr  = r_pointer + ADDR_W'(r_idx);
                if (r_idx == C_LAST_IDX) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_drain == C_LAST_DRAIN) begin
                    w_next = S_HOLD;
                end
            end
            S_HOLD: begin
                loaded = 1'b1;
                if (!load) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // TOTAL may equal 2^ADDR_W, so the advance is evaluated one bit wider.
    assign w_ptr_sum  = {1'b0, r_pointer} + C_STEP;
    assign w_ptr_next = (w_ptr_sum == C_TOTAL) ? '0 : w_ptr_sum[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_idx     <= '0;
            r_drain   <= '0;
            r_pointer <= '0;
            r_counter <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_idx   <= '0;
                    r_drain <= '0;
                end
                S_REQ: begin
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == C_LAST_IDX) begin
                        r_pointer <= w_ptr_next;
                    end
                end
                S_DRAIN: begin
                    r_drain <= r_drain + 1'b1;
                    if (r_drain == C_LAST_DRAIN) begin
                        r_counter <= (r_pointer != '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Each stage carries the lane index of a read still in flight.
    generate
        for (genvar s = 0; s < MEM_LAT; s++) begin : g_pipe
            if (s == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (w_flush) begin
                        r_vld[s]  <= 1'b0;
                        r_tidx[s] <= '0;
                    end else begin
                        r_vld[s]  <= mem_rd_en;
                        r_tidx[s] <= r_idx;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    if (w_flush) begin
                        r_vld[s]  <= 1'b0;
                        r_tidx[s] <= '0;
                    end else begin
                        r_vld[s]  <= r_vld[s-1];
                        r_tidx[s] <= r_tidx[s-1];
                    end
                end
            end
        end
    endgenerate

    generate
        for (genvar k = 0; k < SAMPLES; k++) begin : g_lane
            always_ff @(posedge clk) begin
                if (w_flush) begin
                    r_a_lane[k] <= '0;
                    r_b_lane[k] <= '0;
                end else if (r_vld[MEM_LAT-1] && (r_tidx[MEM_LAT-1] == IDX_W'(k))) begin
                    r_a_lane[k] <= mem_a_data;
                    r_b_lane[k] <= mem_b_data;
                end
            end
            assign a_out[k*DATA_W +: DATA_W] = r_a_lane[k];
            assign b_out[k*DATA_W +: DATA_W] = r_b_lane[k];
        end
    endgenerate

    assign counter = r_counter;

endmodule
`default_nettype wire

// File: tb/tb_sad_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_sad_fetch
// Brief    : Directed self-checking bench for sad_fetch (MEM_LAT=1 and 3).
// Revision : 1.0
// ============================================================================
module tb_sad_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic        load = 1'b0;
    logic        load3 = 1'b0;

    logic [3:0]  mem_addr, mem_addr3;
    logic        mem_rd_en, mem_rd_en3;
    logic [7:0]  mem_a_data, mem_b_data, mem_a_data3, mem_b_data3;
    logic [31:0] a_out, b_out, a_out3, b_out3;
    logic        loaded, loaded3, counter, counter3;

    int n_tests = 0;
    int n_fail  = 0;
    int strobes = 0;

    always #5 clk = ~clk;

    sad_fetch #(.DATA_W(8), .SAMPLES(4), .TOTAL(16), .ADDR_W(4), .MEM_LAT(1)) dut (
        .clk(clk), .rst(rst), .clear(clear), .load(load),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
        .mem_a_data(mem_a_data), .mem_b_data(mem_b_data),
        .a_out(a_out), .b_out(b_out), .loaded(loaded), .counter(counter)
    );

    sad_fetch #(.DATA_W(8), .SAMPLES(4), .TOTAL(16), .ADDR_W(4), .MEM_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .clear(clear), .load(load3),
        .mem_addr(mem_addr3), .mem_rd_en(mem_rd_en3),
        .mem_a_data(mem_a_data3), .mem_b_data(mem_b_data3),
        .a_out(a_out3), .b_out(b_out3), .loaded(loaded3), .counter(counter3)
    );

    // Memory models: A[i]=i, B[i]=0x80+i; 0xEE on idle cycles.
    logic       v1;
    logic [3:0] p1;
    logic       v3 [3];
    logic [3:0] p3 [3];

    always @(posedge clk) begin
        v1 <= mem_rd_en;
        p1 <= mem_addr;
        v3[0] <= mem_rd_en3;
        p3[0] <= mem_addr3;
        for (int s = 1; s < 3; s++) begin
            v3[s] <= v3[s-1];
            p3[s] <= p3[s-1];
        end
        if (mem_rd_en) strobes <= strobes + 1;
    end

    assign mem_a_data  = v1 ? {4'h0, p1} : 8'hEE;
    assign mem_b_data  = v1 ? {4'h8, p1} : 8'hEE;
    assign mem_a_data3 = v3[2] ? {4'h0, p3[2]} : 8'hEE;
    assign mem_b_data3 = v3[2] ? {4'h8, p3[2]} : 8'hEE;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] grp(input logic [7:0] base);
        return {base + 8'd3, base + 8'd2, base + 8'd1, base};
    endfunction

    // One fetch driven by a controller model: load drops one cycle after loaded.
    task automatic run_group(input logic [7:0] base, input logic exp_cnt);
        int k = 0;
        load = 1'b1;
        tick();
        for (int c = 0; c < 20 && !loaded; c++) begin
            if (mem_rd_en) begin
                chk("grp_addr", {28'd0, mem_addr}, {24'd0, base} + k);
                k++;
            end
            tick();
        end
        chk("grp_loaded", {31'd0, loaded}, 32'd1);
        chk("grp_strobes", k, 32'd4);
        chk("grp_a_out", a_out, grp(base));
        chk("grp_b_out", b_out, grp(base + 8'h80));
        chk("grp_counter", {31'd0, counter}, {31'd0, exp_cnt});
        tick();
        load = 1'b0;
        tick();
        chk("grp_release", {31'd0, loaded}, 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_addr"}, {28'd0, mem_addr}, 32'd0);
        chk({tag, "_rd_en"}, {31'd0, mem_rd_en}, 32'd0);
        chk({tag, "_a_out"}, a_out, 32'd0);
        chk({tag, "_b_out"}, b_out, 32'd0);
        chk({tag, "_loaded"}, {31'd0, loaded}, 32'd0);
        chk({tag, "_counter"}, {31'd0, counter}, 32'd0);
    endtask

    initial begin
        int s0;

        // Reset with load asserted
        rst = 1'b1;
        load = 1'b1;
        tick();
        tick();
        chk_zero("reset");
        rst = 1'b0;
        load = 1'b0;
        tick();
        chk("idle_rd_en", {31'd0, mem_rd_en}, 32'd0);

        // Single group, load sampled at edge 0
        s0 = strobes;
        load = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("single_addr", {28'd0, mem_addr}, i);
            chk("single_rd_en", {31'd0, mem_rd_en}, 32'd1);
            tick();
        end
        chk("single_drain_rd", {31'd0, mem_rd_en}, 32'd0);
        chk("single_drain_ld", {31'd0, loaded}, 32'd0);
        tick();
        chk("single_loaded", {31'd0, loaded}, 32'd1);
        chk("single_a_out", a_out, 32'h03020100);
        chk("single_b_out", b_out, 32'h83828180);
        chk("single_counter", {31'd0, counter}, 32'd1);

        // Hold with load high
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_loaded", {31'd0, loaded}, 32'd1);
            chk("hold_a_out", a_out, 32'h03020100);
            chk("hold_b_out", b_out, 32'h83828180);
        end
        chk("hold_strobes", strobes - s0, 32'd4);
        load = 1'b0;
        tick();
        chk("hold_release", {31'd0, loaded}, 32'd0);

        // Full block from pointer 0, then wrap
        clear = 1'b1;
        tick();
        clear = 1'b0;
        run_group(8'd0, 1'b1);
        run_group(8'd4, 1'b1);
        run_group(8'd8, 1'b1);
        run_group(8'd12, 1'b0);
        chk("block_final_a", a_out, 32'h0F0E0D0C);
        run_group(8'd0, 1'b1);

        // Abort with rst during third REQ cycle of group at pointer 4
        load = 1'b1;
        tick();
        tick();
        tick();
        chk("abort_rst_addr", {28'd0, mem_addr}, 32'd6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        load = 1'b0;
        chk_zero("abort_rst");
        tick();
        chk("abort_rst_idle_a", a_out, 32'd0);
        run_group(8'd0, 1'b1);

        // Same abort with clear
        load = 1'b1;
        tick();
        tick();
        tick();
        chk("abort_clr_addr", {28'd0, mem_addr}, 32'd6);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        load = 1'b0;
        chk_zero("abort_clr");
        tick();
        chk("abort_clr_idle_a", a_out, 32'd0);
        run_group(8'd0, 1'b1);

        // MEM_LAT=3 instance
        load3 = 1'b1;
        tick();
        for (int c = 0; c < 7; c++) begin
            if (c < 4) begin
                chk("lat3_addr", {28'd0, mem_addr3}, c);
                chk("lat3_rd_en", {31'd0, mem_rd_en3}, 32'd1);
            end else begin
                chk("lat3_rd_idle", {31'd0, mem_rd_en3}, 32'd0);
            end
            chk("lat3_not_loaded", {31'd0, loaded3}, 32'd0);
            tick();
        end
        chk("lat3_loaded", {31'd0, loaded3}, 32'd1);
        chk("lat3_a_out", a_out3, 32'h03020100);
        chk("lat3_b_out", b_out3, 32'h83828180);
        chk("lat3_counter", {31'd0, counter3}, 32'd1);
        load3 = 1'b0;
        tick();
        chk("lat3_release", {31'd0, loaded3}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
